avalon_mm_timeout_guard: RTL and testbench



---
 rtl/avalon_mm_timeout_guard_if.sv | 26 ++
 rtl/avalon_mm_timeout_guard.sv | 112 +++++++++++
 tb/tb_avalon_mm_timeout_guard.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_mm_timeout_guard_if.sv
// Avalon-MM request/response bundle shared by master and slave sides.
// The master drives the request; the slave returns data and stalls.
interface avalon_mm_timeout_guard_if #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int BYTEENABLE_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]       address;
    logic [BYTEENABLE_WIDTH-1:0] byteenable;
    logic                        read;
    logic                        write;
    logic [DATA_WIDTH-1:0]       writedata;
    logic [DATA_WIDTH-1:0]       readdata;
    logic [1:0]                  response;
    logic                        waitrequest;

    modport master (
        output address, byteenable, read, write, writedata,
        input  readdata, response, waitrequest
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output readdata, response, waitrequest
    );
endinterface

// File: rtl/avalon_mm_timeout_guard.sv
// Avalon-MM watchdog: passes transfers through and aborts any transfer
// stalled by waitrequest for TIMEOUT_CYCLES with an error response.
module avalon_mm_timeout_guard #(
    parameter int         ADDR_WIDTH       = 32,
    parameter int         DATA_WIDTH       = 32,
    parameter int         BYTEENABLE_WIDTH = DATA_WIDTH / 8,
    parameter int         TIMEOUT_CYCLES   = 1024,
    parameter int         CNT_WIDTH        = 16,
    parameter logic [1:0] ERR_RESPONSE     = 2'b11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    avalon_mm_timeout_guard_if.slave   avalon_mm_in,
    avalon_mm_timeout_guard_if.master  avalon_mm_out,
    output logic                       timeout_pulse,
    output logic [CNT_WIDTH-1:0]       timeout_count
);

    typedef enum logic [0:0] {
        PASS  = 1'b0,
        ABORT = 1'b1
    } state_t;

    // A zero timeout turns the guard into a plain wire-through.
    localparam bit ENABLE = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_WIDTH-1:0] LIMIT =
        ENABLE ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t                      r_state;
    state_t                      w_next;
    logic [CNT_WIDTH-1:0]        r_stall_cnt;
    logic [CNT_WIDTH-1:0]        w_stall_nxt;
    logic [CNT_WIDTH-1:0]        r_count;
    logic                        r_pulse;
    logic                        w_req;
    logic                        w_abort;
    logic [ADDR_WIDTH-1:0]       w_addr;
    logic [BYTEENABLE_WIDTH-1:0] w_be;

    assign w_req  = avalon_mm_in.read | avalon_mm_in.write;
    assign w_addr = avalon_mm_in.address;
    assign w_be   = avalon_mm_in.byteenable;

    assign timeout_pulse = r_pulse;
    assign timeout_count = r_count;

    // Next state, stall counting and the pass-through / abort datapath.
    always_comb begin
        w_next      = r_state;
        w_abort     = 1'b0;
        w_stall_nxt = '0;

        avalon_mm_out.address    = w_addr;
        avalon_mm_out.byteenable = w_be;
        avalon_mm_out.read       = avalon_mm_in.read;
        avalon_mm_out.write      = avalon_mm_in.write;
        avalon_mm_out.writedata  = avalon_mm_in.writedata;
        avalon_mm_in.readdata    = avalon_mm_out.readdata;
        avalon_mm_in.response    = avalon_mm_out.response;
        avalon_mm_in.waitrequest = avalon_mm_out.waitrequest;

        unique case (r_state)
            PASS: begin
                if (w_req && avalon_mm_out.waitrequest) begin
                    if (ENABLE && r_stall_cnt == LIMIT) begin
                        w_abort = 1'b1;
                        w_next  = ABORT;
                    end else if (ENABLE) begin
                        w_stall_nxt = r_stall_cnt + ONE;
                    end
                end
            end
            ABORT: begin
                w_next                   = PASS;
                avalon_mm_out.read       = 1'b0;
                avalon_mm_out.write      = 1'b0;
                avalon_mm_in.waitrequest = 1'b0;
                avalon_mm_in.response    = ERR_RESPONSE;
                avalon_mm_in.readdata    = {DATA_WIDTH{1'b0}};
            end
            default: begin
                w_next = PASS;
            end
        endcase

        // Hold the fabric quiet and the master stalled while in reset.
        if (!rst_n) begin
            avalon_mm_out.read       = 1'b0;
            avalon_mm_out.write      = 1'b0;
            avalon_mm_in.waitrequest = 1'b1;
        end
    end

    // State, stall counter, abort strobe and saturating abort counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PASS;
            r_stall_cnt <= '0;
            r_pulse     <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state     <= w_next;
            r_stall_cnt <= w_stall_nxt;
            r_pulse     <= w_abort;
            if (w_abort && r_count != '1) begin
                r_count <= r_count + ONE;
            end
        end
    end

endmodule

// File: tb/tb_avalon_mm_timeout_guard.sv
// Directed bench for avalon_mm_timeout_guard: a guarded instance with an
// 8-cycle timeout and a second instance with the guard disabled.
module tb_avalon_mm_timeout_guard;

    logic        clk;
    logic        rst_n;
    logic        b_pulse;
    logic [15:0] b_count;
    logic        z_pulse;
    logic [15:0] z_count;

    int n_tests = 0;
    int n_fail  = 0;

    avalon_mm_timeout_guard_if #(32, 32, 4) m_if ();
    avalon_mm_timeout_guard_if #(32, 32, 4) s_if ();
    avalon_mm_timeout_guard_if #(32, 32, 4) m0_if ();
    avalon_mm_timeout_guard_if #(32, 32, 4) s0_if ();

    avalon_mm_timeout_guard #(
        .TIMEOUT_CYCLES(8),
        .CNT_WIDTH(16)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .avalon_mm_in(m_if.slave),
        .avalon_mm_out(s_if.master),
        .timeout_pulse(b_pulse),
        .timeout_count(b_count)
    );

    avalon_mm_timeout_guard #(
        .TIMEOUT_CYCLES(0),
        .CNT_WIDTH(16)
    ) u_dut0 (
        .clk(clk),
        .rst_n(rst_n),
        .avalon_mm_in(m0_if.slave),
        .avalon_mm_out(s0_if.master),
        .timeout_pulse(z_pulse),
        .timeout_count(z_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 2ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Checks of the guarded instance's abort cycle.
    task automatic chk_abort(input string tag, input logic [15:0] cnt);
        chk({tag, " wr"}, 64'(m_if.waitrequest), 64'd0);
        chk({tag, " rsp"}, 64'(m_if.response), 64'd3);
        chk({tag, " rdata"}, 64'(m_if.readdata), 64'd0);
        chk({tag, " oread"}, 64'(s_if.read), 64'd0);
        chk({tag, " owrite"}, 64'(s_if.write), 64'd0);
        chk({tag, " pulse"}, 64'(b_pulse), 64'd1);
        chk({tag, " count"}, 64'(b_count), 64'(cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        m_if.address = '0; m_if.byteenable = '0;
        m_if.read = 1'b1; m_if.write = 1'b0; m_if.writedata = '0;
        s_if.readdata = '0; s_if.response = '0; s_if.waitrequest = 1'b1;
        m0_if.address = '0; m0_if.byteenable = '0;
        m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.writedata = '0;
        s0_if.readdata = '0; s0_if.response = '0;
        s0_if.waitrequest = 1'b0;
        #3;
        chk("rst oread", 64'(s_if.read), 64'd0);
        chk("rst iwait", 64'(m_if.waitrequest), 64'd1);
        chk("rst pulse", 64'(b_pulse), 64'd0);
        chk("rst count", 64'(b_count), 64'd0);
        step();
        m_if.read = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Read stalled 3 cycles, then completes.
        m_if.address = 32'h10; m_if.byteenable = 4'hF; m_if.read = 1'b1;
        s_if.waitrequest = 1'b1;
        #1;
        chk("t1 oaddr", 64'(s_if.address), 64'h10);
        chk("t1 oread", 64'(s_if.read), 64'd1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) #1;
            chk("t1 stall", 64'(m_if.waitrequest), 64'd1);
            step();
        end
        s_if.waitrequest = 1'b0;
        s_if.readdata = 32'hDEADBEEF; s_if.response = 2'b00;
        #1;
        chk("t1 wr", 64'(m_if.waitrequest), 64'd0);
        chk("t1 rdata", 64'(m_if.readdata), 64'hDEADBEEF);
        chk("t1 rsp", 64'(m_if.response), 64'd0);
        chk("t1 pulse", 64'(b_pulse), 64'd0);
        step();
        m_if.read = 1'b0;
        #1;
        chk("t1 pulse2", 64'(b_pulse), 64'd0);
        chk("t1 count", 64'(b_count), 64'd0);

        // Stuck read: 8 stalled cycles, then the abort cycle.
        step();
        m_if.read = 1'b1; s_if.waitrequest = 1'b1;
        s_if.readdata = 32'h12345678;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t2 stall", 64'(m_if.waitrequest), 64'd1);
            chk("t2 oread", 64'(s_if.read), 64'd1);
            step();
        end
        #1;
        chk_abort("t2 abort", 16'd1);
        step();
        m_if.read = 1'b0;
        #1;
        chk("t2 pulse off", 64'(b_pulse), 64'd0);
        chk("t2 count", 64'(b_count), 64'd1);

        // Write that completes in the cycle the limit is reached.
        step();
        m_if.address = 32'h20; m_if.write = 1'b1;
        m_if.writedata = 32'hCAFEF00D; s_if.waitrequest = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("t3 stall", 64'(m_if.waitrequest), 64'd1);
            step();
        end
        s_if.waitrequest = 1'b0; s_if.response = 2'b00;
        #1;
        chk("t3 wr", 64'(m_if.waitrequest), 64'd0);
        chk("t3 rsp", 64'(m_if.response), 64'd0);
        chk("t3 owrite", 64'(s_if.write), 64'd1);
        chk("t3 wdata", 64'(s_if.writedata), 64'hCAFEF00D);
        chk("t3 pulse", 64'(b_pulse), 64'd0);
        step();
        m_if.write = 1'b0;
        #1;
        chk("t3 pulse2", 64'(b_pulse), 64'd0);
        chk("t3 count", 64'(b_count), 64'd1);

        // Two back-to-back stuck writes.
        step();
        m_if.write = 1'b1; m_if.writedata = 32'h11111111;
        s_if.waitrequest = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t4a stall", 64'(m_if.waitrequest), 64'd1);
            step();
        end
        #1;
        chk_abort("t4a abort", 16'd2);
        step();
        m_if.writedata = 32'h22222222;
        #1;
        chk("t4b fwd", 64'(s_if.write), 64'd1);
        chk("t4b wdata", 64'(s_if.writedata), 64'h22222222);
        chk("t4b stall0", 64'(m_if.waitrequest), 64'd1);
        chk("t4b pulse", 64'(b_pulse), 64'd0);
        for (int i = 1; i < 8; i++) begin
            step();
            #1;
            chk("t4b stall", 64'(m_if.waitrequest), 64'd1);
        end
        step();
        #1;
        chk_abort("t4b abort", 16'd3);
        step();
        m_if.write = 1'b0;

        // Reset on stall cycle 5 of a stuck read.
        step();
        m_if.read = 1'b1; s_if.waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t5 stall", 64'(m_if.waitrequest), 64'd1);
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("t5 oread", 64'(s_if.read), 64'd0);
        chk("t5 iwait", 64'(m_if.waitrequest), 64'd1);
        chk("t5 count", 64'(b_count), 64'd0);
        chk("t5 pulse", 64'(b_pulse), 64'd0);
        step();
        rst_n = 1'b1;
        // Stall counter must restart from zero: a full 8 stalls again.
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t5 restall", 64'(m_if.waitrequest), 64'd1);
            step();
        end
        #1;
        chk_abort("t5 abort", 16'd1);
        step();
        m_if.read = 1'b0;
        step();
        m_if.read = 1'b1; m_if.address = 32'h44;
        s_if.waitrequest = 1'b1;
        step();
        s_if.waitrequest = 1'b0; s_if.readdata = 32'hA5A55A5A;
        s_if.response = 2'b00;
        #1;
        chk("t5 fresh wr", 64'(m_if.waitrequest), 64'd0);
        chk("t5 fresh rdata", 64'(m_if.readdata), 64'hA5A55A5A);
        chk("t5 fresh rsp", 64'(m_if.response), 64'd0);
        step();
        m_if.read = 1'b0;
        #1;
        chk("t5 fresh count", 64'(b_count), 64'd1);

        // Disabled guard: 2000 stalls then normal completion.
        step();
        m0_if.read = 1'b1; m0_if.address = 32'h80;
        s0_if.waitrequest = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            #1;
            chk("t6 stall", 64'(m0_if.waitrequest), 64'd1);
            chk("t6 pulse", 64'(z_pulse), 64'd0);
            step();
        end
        s0_if.waitrequest = 1'b0; s0_if.readdata = 32'h0BADF00D;
        s0_if.response = 2'b01;
        #1;
        chk("t6 oread", 64'(s0_if.read), 64'd1);
        chk("t6 wr", 64'(m0_if.waitrequest), 64'd0);
        chk("t6 rdata", 64'(m0_if.readdata), 64'h0BADF00D);
        chk("t6 rsp", 64'(m0_if.response), 64'd1);
        step();
        m0_if.read = 1'b0;
        #1;
        chk("t6 count", 64'(z_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
